// File: rtl/lsu_controller.sv
// lsu_controller: load/store sequencer between core and data memory; optional REQ timeout via LSU_TIMEOUT_EN
module lsu_controller #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        core_req_i,
  input  logic        core_we_i,
  input  logic [2:0]  core_size_i,
  input  logic [31:0] core_addr_i,
  input  logic [31:0] core_wd_i,
  output logic [31:0] core_rd_o,
  output logic        core_stall_o,
  output logic        misaligned_o,
  output logic        bus_err_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wd_o,
  input  logic [31:0] mem_rd_i,
  input  logic        mem_ready_i
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  logic [1:0]  r_state;
  logic        r_we;
  logic [2:0]  r_size;
  logic [1:0]  r_off;
  logic [3:0]  r_be;
  logic [31:0] r_addr;
  logic [31:0] r_wd;
  logic [31:0] r_rd;
  logic        r_req;
  logic        r_bus_err;
  logic        w_fault;
  logic        w_idle;
  logic        w_start;
  logic        w_abort;
  logic [3:0]  w_be;
  logic [31:0] w_wd;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_fmt;

  assign w_fault = (core_size_i[1:0] == 2'd3) | (core_size_i[2] & core_size_i[1]) |
                   ((core_size_i[1:0] == 2'd1) & core_addr_i[0]) |
                   ((core_size_i == 3'd2) & (|core_addr_i[1:0]));
  assign w_idle       = r_state == S_IDLE;
  assign misaligned_o = core_req_i & w_idle & w_fault;
  assign core_stall_o = core_req_i & ~(w_idle & w_fault) & (r_state != S_DONE);
  assign w_start      = w_idle & core_req_i & ~w_fault;

  assign w_wd = (core_size_i[1:0] == 2'd0) ? {4{core_wd_i[7:0]}} :
                (core_size_i[1:0] == 2'd1) ? {2{core_wd_i[15:0]}} : core_wd_i;
  assign w_be = (core_size_i[1:0] == 2'd0) ? (4'b0001 << core_addr_i[1:0]) :
                (core_size_i[1:0] == 2'd1) ? (core_addr_i[1] ? 4'b1100 : 4'b0011) : 4'b1111;

  assign w_byte = mem_rd_i[{r_off, 3'b000} +: 8];
  assign w_half = r_off[1] ? mem_rd_i[31:16] : mem_rd_i[15:0];
  assign w_fmt  = r_we ? 32'd0 :
                  (r_size[1:0] == 2'd0) ? {{24{~r_size[2] & w_byte[7]}}, w_byte} :
                  (r_size[1:0] == 2'd1) ? {{16{~r_size[2] & w_half[15]}}, w_half} : mem_rd_i;

`ifdef LSU_TIMEOUT_EN
  localparam int CW = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [CW-1:0] r_cnt;
  assign w_abort = (r_state == S_REQ) & ~mem_ready_i & (r_cnt == CW'(TIMEOUT_CYCLES - 1));
  // count REQ cycles without ready; cleared whenever outside REQ so each access starts at zero
  always_ff @(posedge clk_i) begin
    if (!rst_ni || r_state != S_REQ) r_cnt <= '0;
    else if (!mem_ready_i) r_cnt <= r_cnt + 1'b1;
  end
`else
  logic w_unused;
  assign w_unused = ^TIMEOUT_CYCLES;
  assign w_abort  = 1'b0;
`endif

  // sequencer: latch the access in IDLE, hold the bus in REQ, present load data in DONE
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state   <= S_IDLE;
      r_we      <= 1'b0;
      r_size    <= 3'd0;
      r_off     <= 2'd0;
      r_be      <= 4'd0;
      r_addr    <= 32'd0;
      r_wd      <= 32'd0;
      r_rd      <= 32'd0;
      r_req     <= 1'b0;
      r_bus_err <= 1'b0;
    end else begin
      r_bus_err <= 1'b0;
      if (w_start) begin
        r_state <= S_REQ;
        r_req   <= 1'b1;
        r_we    <= core_we_i;
        r_size  <= core_size_i;
        r_off   <= core_addr_i[1:0];
        r_be    <= core_we_i ? w_be : 4'd0;
        r_addr  <= {core_addr_i[31:2], 2'b00};
        r_wd    <= w_wd;
      end else if (r_state == S_REQ && (mem_ready_i || w_abort)) begin
        r_state   <= S_DONE;
        r_req     <= 1'b0;
        r_rd      <= mem_ready_i ? w_fmt : 32'd0;
        r_bus_err <= ~mem_ready_i;
      end else if (r_state != S_REQ) begin
        r_state <= S_IDLE;
      end
    end
  end

  assign core_rd_o  = r_rd;
  assign bus_err_o  = r_bus_err;
  assign mem_req_o  = r_req;
  assign mem_we_o   = r_we;
  assign mem_be_o   = r_be;
  assign mem_addr_o = r_addr;
  assign mem_wd_o   = r_wd;
endmodule

// File: tb/tb_lsu_controller.sv
// tb_lsu_controller: randomized self-checking bench against a byte-lane reference model
module tb_lsu_controller;
  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        core_req_i = 1'b0;
  logic        core_we_i = 1'b0;
  logic [2:0]  core_size_i = 3'd0;
  logic [31:0] core_addr_i = 32'd0;
  logic [31:0] core_wd_i = 32'd0;
  logic [31:0] mem_rd_i = 32'd0;
  logic        mem_ready_i = 1'b0;
  logic [31:0] core_rd_o, mem_addr_o, mem_wd_o;
  logic        core_stall_o, misaligned_o, bus_err_o, mem_req_o, mem_we_o;
  logic [3:0]  mem_be_o;
  int errors = 0;
  int checks = 0;

  lsu_controller #(.TIMEOUT_CYCLES(4)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .core_req_i(core_req_i), .core_we_i(core_we_i),
    .core_size_i(core_size_i), .core_addr_i(core_addr_i), .core_wd_i(core_wd_i),
    .core_rd_o(core_rd_o), .core_stall_o(core_stall_o), .misaligned_o(misaligned_o),
    .bus_err_o(bus_err_o), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
    .mem_addr_o(mem_addr_o), .mem_wd_o(mem_wd_o), .mem_rd_i(mem_rd_i), .mem_ready_i(mem_ready_i)
  );

  always #5 clk_i = ~clk_i;

  function automatic bit ref_fault(input logic [2:0] s, input logic [31:0] a);
    return (s == 0 || s == 4) ? 1'b0 : (s == 1 || s == 5) ? (a % 2 != 0) : (s == 2) ? (a % 4 != 0) : 1'b1;
  endfunction

  function automatic int nbytes(input logic [2:0] s);
    return (s % 4 == 0) ? 1 : (s % 4 == 1) ? 2 : 4;
  endfunction

  function automatic logic [3:0] ref_be(input bit we, input logic [2:0] s, input logic [31:0] a);
    return we ? 4'(((1 << nbytes(s)) - 1) << (a % 4)) : 4'd0;
  endfunction

  function automatic logic [31:0] ref_wd(input logic [2:0] s, input logic [31:0] d);
    logic [31:0] r;
    int n;
    n = nbytes(s);
    for (int i = 0; i < 4; i++) r[8*i +: 8] = d[8*(i % n) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] ref_rd(input bit we, input logic [2:0] s, input logic [31:0] a, input logic [31:0] w);
    logic [31:0] v, mask;
    int n;
    n = nbytes(s);
    if (we) return 32'd0;
    if (n == 4) return w;
    mask = (32'd1 << (8 * n)) - 32'd1;
    v = (w >> (8 * (a % 4))) & mask;
    if (s < 4 && v[8*n-1]) v = v | ~mask;
    return v;
  endfunction

  task automatic do_access(input bit we, input logic [2:0] s, input logic [31:0] a, input logic [31:0] d,
                           input logic [31:0] w, input int delay);
    bit f;
    f = ref_fault(s, a);
    @(negedge clk_i);
    core_req_i = 1'b1; core_we_i = we; core_size_i = s; core_addr_i = a; core_wd_i = d; mem_ready_i = 1'b0;
    #1;
    checks++;
    if ({misaligned_o, core_stall_o} !== {f, ~f}) begin
      errors++; $display("FAIL idle_flags a=%h s=%0d: misaligned,stall got %b want %b", a, s, {misaligned_o, core_stall_o}, {f, ~f});
    end
    if (f) begin
      @(negedge clk_i);
      checks++;
      if (mem_req_o !== 1'b0) begin errors++; $display("FAIL fault_no_req: mem_req_o got %b want 0", mem_req_o); end
      core_req_i = 1'b0;
      return;
    end
    for (int k = 0; k <= delay; k++) begin
      @(negedge clk_i);
      checks++;
      if ({mem_req_o, mem_we_o, mem_be_o, mem_addr_o, core_stall_o} !== {1'b1, we, ref_be(we, s, a), a & ~32'd3, 1'b1}) begin
        errors++;
        $display("FAIL req_bus cyc%0d: req,we,be,addr,stall got %b %b %b %h %b want 1 %b %b %h 1", k,
                 mem_req_o, mem_we_o, mem_be_o, mem_addr_o, core_stall_o, we, ref_be(we, s, a), a & ~32'd3);
      end
      if (we) begin
        checks++;
        if (mem_wd_o !== ref_wd(s, d)) begin errors++; $display("FAIL req_wd: got %h want %h", mem_wd_o, ref_wd(s, d)); end
      end
      core_wd_i = $urandom;
      core_we_i = ~we;
      mem_ready_i = (k == delay);
      mem_rd_i = (k == delay) ? w : $urandom;
    end
    @(negedge clk_i);
    checks++;
    if ({mem_req_o, core_stall_o, bus_err_o, core_rd_o} !== {3'b000, ref_rd(we, s, a, w)}) begin
      errors++;
      $display("FAIL done: req,stall,err got %b%b%b rd %h want 000 rd %h", mem_req_o, core_stall_o, bus_err_o, core_rd_o, ref_rd(we, s, a, w));
    end
    core_req_i = 1'b0; mem_ready_i = 1'b0; mem_rd_i = $urandom;
  endtask

  task automatic test_reset;
    rst_ni = 1'b0;
    repeat (2) @(negedge clk_i);
    checks++;
    if ({mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wd_o, core_rd_o, bus_err_o, core_stall_o, misaligned_o} !== 104'd0) begin
      errors++;
      $display("FAIL reset: req %b we %b be %b addr %h wd %h rd %h err %b stall %b mis %b want all 0",
               mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wd_o, core_rd_o, bus_err_o, core_stall_o, misaligned_o);
    end
    rst_ni = 1'b1;
  endtask

  task automatic test_directed;
    do_access(1'b0, 3'd0, 32'h103, 32'h0, 32'h80FF_0000, 0);
    checks++;
    if (core_rd_o !== 32'hFFFF_FF80) begin errors++; $display("FAIL lb_rd: got %h want ffffff80", core_rd_o); end
    do_access(1'b1, 3'd1, 32'h206, 32'h1234_ABCD, 32'h0, 1);
    checks++;
    if ({mem_wd_o, mem_be_o, mem_addr_o} !== {32'hABCD_ABCD, 4'b1100, 32'h204}) begin
      errors++; $display("FAIL sh_bus: wd %h be %b addr %h want abcdabcd 1100 00000204", mem_wd_o, mem_be_o, mem_addr_o);
    end
    do_access(1'b0, 3'd2, 32'h102, 32'h0, 32'h0, 0);
    do_access(1'b0, 3'd5, 32'h002, 32'h0, 32'hBEEF_1234, 5);
    checks++;
    if (core_rd_o !== 32'h0000_BEEF) begin errors++; $display("FAIL lhu_rd: got %h want 0000beef", core_rd_o); end
  endtask

  task automatic test_random;
    for (int i = 0; i < 60; i++) begin
      logic [31:0] a;
      a = $urandom;
      if (i % 2 == 0) a = a & ~32'd3;
      do_access(1'($urandom % 2), 3'($urandom % 8), a, $urandom, $urandom, int'($urandom % 4));
    end
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 10; i++)
      do_access(1'(i % 2), (i % 3 == 0) ? 3'd4 : 3'd2, 32'h1000 + 32'(4 * i), $urandom, $urandom, 0);
  endtask

  task automatic test_reset_mid;
    @(negedge clk_i);
    core_req_i = 1'b1; core_we_i = 1'b0; core_size_i = 3'd2; core_addr_i = 32'h40; mem_ready_i = 1'b0;
    @(negedge clk_i);
    checks++;
    if (mem_req_o !== 1'b1) begin errors++; $display("FAIL rstmid_req: got %b want 1", mem_req_o); end
    rst_ni = 1'b0; core_req_i = 1'b0;
    @(negedge clk_i);
    rst_ni = 1'b1;
    checks++;
    if ({mem_req_o, core_rd_o, core_stall_o} !== 34'd0) begin
      errors++; $display("FAIL rstmid_clear: req %b rd %h stall %b want 0", mem_req_o, core_rd_o, core_stall_o);
    end
    mem_ready_i = 1'b1; mem_rd_i = 32'hDEAD_BEEF;
    @(negedge clk_i);
    mem_ready_i = 1'b0;
    @(negedge clk_i);
    checks++;
    if ({mem_req_o, core_rd_o, bus_err_o} !== 34'd0) begin
      errors++; $display("FAIL stray_ready: req %b rd %h err %b want 0", mem_req_o, core_rd_o, bus_err_o);
    end
  endtask

`ifdef LSU_TIMEOUT_EN
  task automatic test_timeout;
    bit seen;
    seen = 1'b0;
    @(negedge clk_i);
    core_req_i = 1'b1; core_we_i = 1'b0; core_size_i = 3'd2; core_addr_i = 32'h80; mem_ready_i = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk_i);
      if (bus_err_o) begin
        seen = 1'b1;
        checks++;
        if ({core_rd_o, core_stall_o, mem_req_o} !== 34'd0) begin
          errors++; $display("FAIL timeout_done: rd %h stall %b req %b want 0", core_rd_o, core_stall_o, mem_req_o);
        end
      end
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL timeout_seen: bus_err_o got 0 want pulse"); end
    core_req_i = 1'b0;
    @(negedge clk_i);
    checks++;
    if ({bus_err_o, mem_req_o} !== 2'b00) begin errors++; $display("FAIL timeout_pulse: err,req got %b want 00", {bus_err_o, mem_req_o}); end
  endtask
`else
  task automatic test_no_timeout;
    do_access(1'b0, 3'd2, 32'h80, 32'h0, 32'h1357_9BDF, 300);
  endtask
`endif

  initial begin
    test_reset;
    test_directed;
    test_random;
    test_back_to_back;
    test_reset_mid;
`ifdef LSU_TIMEOUT_EN
    test_timeout;
`else
    test_no_timeout;
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/lsu_controller.md
Name: lsu_controller

Overview:
- Load/store sequencer between the core datapath and the data-memory port.
- Takes the mem_req/mem_we/mem_size controls produced by instruction decode, plus the ALU-computed address and the rs2 data.
- Drives a request/ready memory handshake, stalls the core until the access completes, and returns size-formatted read data for write-back.
- Performs misalignment checks, byte-enable generation, write-data replication and load sign/zero extension.

Parameters:
- TIMEOUT_CYCLES, 255: maximum cycles spent in REQ before abort. Used only with LSU_TIMEOUT_EN.

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_ni  in  1  synchronous reset, active-low.
- core_req_i  in  1  load/store requested by the current instruction.
- core_we_i  in  1  1 = store, 0 = load.
- core_size_i  in  3  size encoding: LDST_B=0, LDST_H=1, LDST_W=2, LDST_BU=4, LDST_HU=5.
- core_addr_i  in  32  byte address.
- core_wd_i  in  32  store data (rs2).
- core_rd_o  out  32  formatted load data; valid in the DONE cycle.
- core_stall_o  out  1  hold PC/pipeline.
- misaligned_o  out  1  access fault: misaligned address or illegal size.
- bus_err_o  out  1  one-cycle pulse on timeout abort.
- mem_req_o  out  1  memory request.
- mem_we_o  out  1  memory write enable.
- mem_be_o  out  4  byte enables.
- mem_addr_o  out  32  word address (byte address with [1:0] forced to 00).
- mem_wd_o  out  32  memory write data.
- mem_rd_i  in  32  memory read word.
- mem_ready_i  in  1  access complete; read data valid this cycle.

Behaviour:
- Reset (rst_ni low at posedge): state IDLE. All registered outputs 0: mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wd_o, core_rd_o, bus_err_o. Applies mid-transaction too; the in-flight access is dropped with no completion.
- Fault detection (combinational), sets misaligned_o = core_req_i in IDLE when:
  - size H/HU with addr[0]=1,
  - size W with addr[1:0]≠0,
  - size 3, 6 or 7.
- On a fault: no memory access, core_stall_o=0, state stays IDLE.
- IDLE: on core_req_i with no fault, register we, be, word address, replicated wdata, size and addr[1:0]; go to REQ.
- REQ:
  - mem_req_o=1; mem_we_o, mem_be_o, mem_addr_o, mem_wd_o held stable.
  - On mem_ready_i: capture formatted mem_rd_i into core_rd_o (stores capture 0); go to DONE.
- DONE: mem_req_o=0, core_stall_o=0; next state IDLE unconditionally.
- core_stall_o = core_req_i & ~fault & (state≠DONE). Combinational so the core stalls in the request cycle itself.
- Latency: minimum 3 cycles per access (IDLE→REQ→DONE) with mem_ready_i=1 in the first REQ cycle. Each cycle of ready delay adds one.
- Store formatting:
  - B: wd = {4{wd[7:0]}}, be = 0001 << addr[1:0].
  - H: wd = {2{wd[15:0]}}, be = addr[1] ? 1100 : 0011.
  - W: wd = wd, be = 1111.
- Load formatting: select the byte/half from mem_rd_i using the registered addr[1:0].
  - B/H sign-extend.
  - BU/HU zero-extend.
  - W passes the word unchanged.
- mem_ready_i outside REQ is ignored.
- core inputs are ignored while in REQ; the registered copy is authoritative.

Optional Feature:
- Macro LSU_TIMEOUT_EN.
- Defined:
  - 8+ bit counter cleared on entry to REQ, incremented each REQ cycle without mem_ready_i.
  - When it reaches TIMEOUT_CYCLES: go to DONE with core_rd_o=0 and pulse bus_err_o for one cycle (the DONE cycle).
  - mem_ready_i and timeout in the same cycle: ready wins.
- Undefined: no counter; REQ waits indefinitely; bus_err_o tied 0.

Test Plan:
- lb, addr=0x103, mem_rd_i=0x80FF_0000, ready in first REQ cycle → mem_addr_o=0x100, be=0000 (load); core_rd_o=0xFFFF_FF80; core_stall_o high 2 cycles then low 1 cycle.
- sh, addr=0x206, wd=0x1234_ABCD → mem_we_o=1, be=1100, mem_wd_o=0xABCD_ABCD, mem_addr_o=0x204.
- lw, addr=0x102 → misaligned_o=1 same cycle, core_stall_o=0, mem_req_o never asserts.
- lhu, addr=0x002, mem_ready_i delayed 5 cycles, mem_rd_i=0xBEEF_1234 → mem_req_o high 6 cycles; core_rd_o=0x0000_BEEF; total stall 7 cycles.
- rst_ni low for one cycle during REQ → next cycle IDLE, mem_req_o=0, core_rd_o=0; a later mem_ready_i pulse is ignored.
- LSU_TIMEOUT_EN, TIMEOUT_CYCLES=4, mem_ready_i held 0 → bus_err_o pulses once, core_rd_o=0, core_stall_o released, state returns to IDLE.
